// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM driver: colour-word field positions,
// PWM resolution and the per-channel duty comparison.
package rgb_pwm_driver_pkg;

    localparam int RED_MSB   = 23;
    localparam int RED_LSB   = 16;
    localparam int GREEN_MSB = 15;
    localparam int GREEN_LSB = 8;
    localparam int BLUE_MSB  = 7;
    localparam int BLUE_LSB  = 0;

    localparam int PWM_BITS = 8;
    localparam logic [PWM_BITS-1:0] PWM_MAX = 8'hFF;

    typedef logic [PWM_BITS-1:0] pwm_level_t;

    // Full scale is promoted to constant-on so white really is full brightness.
    function automatic logic pwm_level(input pwm_level_t value, input pwm_level_t cnt);
        return (value == PWM_MAX) || (cnt < value);
    endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One colour channel: frame-aligned shadow of the channel value plus the
// registered PWM comparator output.
module pwm_channel
    import rgb_pwm_driver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       load,
    input  pwm_level_t value,
    input  pwm_level_t cnt,
    output logic       out
);

    pwm_level_t shadow_q, shadow_d;
    logic       out_q, out_d;

    // While idle the shadow tracks the input so the first enabled frame
    // already shows the current colour; while running it only moves at a wrap.
    always_comb begin
        shadow_d = shadow_q;
        out_d    = 1'b0;
        if (!enable) begin
            shadow_d = value;
        end else begin
            if (load) begin
                shadow_d = value;
            end
            out_d = pwm_level(shadow_q, cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED; colour is resampled only at frame
// boundaries so a frame never mixes two colours.
module rgb_pwm_driver
    import rgb_pwm_driver_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] light,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b,
    output logic        frame_start
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    pwm_level_t  pwm_cnt_q, pwm_cnt_d;
    logic        frame_start_q, frame_start_d;
    logic        tick;
    logic        wrap;

    assign tick = (pre_cnt_q == PRE_LAST);
    assign wrap = tick && (pwm_cnt_q == PWM_MAX);

    // Disabling parks both counters at zero so re-enabling starts a clean frame.
    always_comb begin
        pre_cnt_d     = '0;
        pwm_cnt_d     = '0;
        frame_start_d = 1'b0;
        if (enable) begin
            pre_cnt_d     = tick ? 16'd0 : pre_cnt_q + 16'd1;
            pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
            frame_start_d = wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    pwm_channel u_red (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (wrap),
        .value  (light[RED_MSB:RED_LSB]),
        .cnt    (pwm_cnt_q),
        .out    (pwm_r)
    );

    pwm_channel u_green (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (wrap),
        .value  (light[GREEN_MSB:GREEN_LSB]),
        .cnt    (pwm_cnt_q),
        .out    (pwm_g)
    );

    pwm_channel u_blue (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (wrap),
        .value  (light[BLUE_MSB:BLUE_LSB]),
        .cnt    (pwm_cnt_q),
        .out    (pwm_b)
    );

    assign frame_start = frame_start_q;

endmodule
